// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: registered single-cycle ops plus iterative mul/div/mod
// with a start/busy/done handshake.
module alu_exec_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       aluCtrl,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic [4:0]       shamt,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             branchTaken,
    output logic             busy,
    output logic             done
);
    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [0:0] {StIdle, StIter} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             taken_q, taken_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] single_res;
    logic             single_taken;
    logic             is_iter;

    logic [WIDTH-1:0] mul_acc;
    logic [WIDTH:0]   div_trial, div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem, div_quo, iter_res;

    // Divide by zero short-circuits to a single-cycle op; mul always iterates.
    assign is_iter = (aluCtrl == 4'd13) || ((aluCtrl[3:1] == 3'b111) && (srcB != '0));

    always_comb begin
        single_res   = '0;
        single_taken = 1'b0;
        unique case (aluCtrl)
            4'd0:  single_res = srcA + srcB;
            4'd1:  single_res = srcA - srcB;
            4'd2:  single_res = srcA & srcB;
            4'd3:  single_res = srcA | srcB;
            4'd4:  single_res = srcA ^ srcB;
            4'd5:  single_res = srcB << shamt;
            4'd6:  single_res = srcB >> shamt;
            4'd7:  single_taken = (srcA == srcB);
            4'd8:  single_taken = (srcA != srcB);
            4'd9:  single_taken = ($signed(srcA) >  $signed(srcB));
            4'd10: single_taken = ($signed(srcA) >= $signed(srcB));
            4'd11: single_taken = ($signed(srcA) <  $signed(srcB));
            4'd12: single_taken = ($signed(srcA) <= $signed(srcB));
            4'd13: single_res = '0;
            4'd14: single_res = '1;
            4'd15: single_res = srcA;
        endcase
        if (single_taken) begin
            single_res = {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // acc is the product accumulator (mul) or partial remainder (div/mod);
    // x is the shifting multiplicand or the dividend/quotient shift register.
    always_comb begin
        mul_acc   = acc_q + (y_q[0] ? x_q : '0);
        div_trial = {acc_q, x_q[WIDTH-1]};
        div_diff  = div_trial - {1'b0, y_q};
        div_ge    = ~div_diff[WIDTH];
        div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];
        div_quo   = {x_q[WIDTH-2:0], div_ge};
        case (op_q)
            4'd13:   iter_res = mul_acc;
            4'd14:   iter_res = div_quo;
            default: iter_res = div_rem;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        acc_d    = acc_q;
        x_d      = x_q;
        y_d      = y_q;
        result_d = result_q;
        zero_d   = zero_q;
        taken_d  = taken_q;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (is_iter) begin
                        state_d = StIter;
                        cnt_d   = '0;
                        op_d    = aluCtrl;
                        acc_d   = '0;
                        x_d     = srcA;
                        y_d     = srcB;
                    end else begin
                        result_d = single_res;
                        zero_d   = (single_res == '0);
                        taken_d  = single_taken;
                        done_d   = 1'b1;
                    end
                end
            end
            StIter: begin
                cnt_d = cnt_q + 1'b1;
                if (op_q == 4'd13) begin
                    acc_d = mul_acc;
                    x_d   = x_q << 1;
                    y_d   = y_q >> 1;
                end else begin
                    acc_d = div_rem;
                    x_d   = div_quo;
                end
                if (cnt_q == CntLast) begin
                    state_d  = StIdle;
                    result_d = iter_res;
                    zero_d   = (iter_res == '0);
                    taken_d  = 1'b0;
                    done_d   = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            op_q     <= '0;
            acc_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            taken_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            x_q      <= x_d;
            y_q      <= y_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            taken_q  <= taken_d;
            done_q   <= done_d;
        end
    end

    assign result      = result_q;
    assign zero        = zero_q;
    assign branchTaken = taken_q;
    assign busy        = (state_q == StIter);
    assign done        = done_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed plan vectors plus randomized
// ops checked against an arithmetic reference model.
module tb_alu_exec_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [3:0]   aluCtrl;
    logic [W-1:0] srcA, srcB, result;
    logic [4:0]   shamt;
    logic         zero, branchTaken, busy, done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .aluCtrl     (aluCtrl),
        .srcA        (srcA),
        .srcB        (srcB),
        .shamt       (shamt),
        .result      (result),
        .zero        (zero),
        .branchTaken (branchTaken),
        .busy        (busy),
        .done        (done)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Returns {taken, result}
    function automatic logic [W:0] model(input logic [3:0] c, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic [4:0] sh);
        logic [2*W-1:0] p;
        logic [W-1:0]   r;
        logic           t;
        r = '0;
        t = 1'b0;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        case (c)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = b << sh;
            4'd6:  r = b >> sh;
            4'd7:  t = (a == b);
            4'd8:  t = (a != b);
            4'd9:  t = ($signed(a) >  $signed(b));
            4'd10: t = ($signed(a) >= $signed(b));
            4'd11: t = ($signed(a) <  $signed(b));
            4'd12: t = ($signed(a) <= $signed(b));
            4'd13: r = p[W-1:0];
            4'd14: r = (b == '0) ? '1 : a / b;
            default: r = (b == '0) ? a : a % b;
        endcase
        if (c >= 4'd7 && c <= 4'd12) r = W'(t);
        return {t, r};
    endfunction

    function automatic int exp_lat(input logic [3:0] c, input logic [W-1:0] b);
        return (c == 4'd13 || (c >= 4'd14 && b != '0)) ? W + 1 : 1;
    endfunction

    // Issues one op and waits (bounded) for done; operands are scrambled after
    // the start edge so any re-sampling would corrupt the result.
    task automatic run_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [4:0] sh, output int lat);
        aluCtrl = c;
        srcA    = a;
        srcB    = b;
        shamt   = sh;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        aluCtrl = 4'($urandom);
        srcA    = $urandom;
        srcB    = $urandom;
        shamt   = 5'($urandom);
        lat     = 1;
        while (done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset;
        rst     = 1'b1;
        start   = 1'b1;
        aluCtrl = 4'd0;
        srcA    = 32'd1;
        srcB    = 32'd2;
        shamt   = '0;
        tick();
        tick();
        tests++;
        if ({result, zero, branchTaken, busy, done} !== '0) begin
            fails++;
            $display("FAIL reset: result=%h zero=%b bt=%b busy=%b done=%b, required all 0",
                     result, zero, branchTaken, busy, done);
        end
        start = 1'b0;
        rst   = 1'b0;
        tick();
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL reset_no_done: done=%b, required 0", done);
        end
    endtask

    task automatic test_plan;
        logic [3:0]   tc[15];
        logic [W-1:0] ta[15], tb[15], tr[15];
        logic [4:0]   ts[15];
        logic         tt[15];
        int           tl[15];
        int           lat;
        tc = '{4'd0, 4'd11, 4'd9, 4'd5, 4'd6, 4'd13, 4'd14, 4'd15, 4'd14, 4'd15,
               4'd10, 4'd12, 4'd8, 4'd1, 4'd13};
        ta = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 32'h10000, 32'd100, 32'd100,
               32'd5, 32'd5, 32'd5, 32'hFFFFFFFD, 32'd3, 32'd0, 32'hFFFFFFFF};
        tb = '{32'hFFFFFFF9, 32'd1, 32'd1, 32'd1, 32'hF0, 32'h10000, 32'd7, 32'd7,
               32'd0, 32'd0, 32'd5, 32'd2, 32'd3, 32'd1, 32'hFFFFFFFF};
        ts = '{5'd0, 5'd0, 5'd0, 5'd31, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0,
               5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
        tr = '{32'd0, 32'd1, 32'd0, 32'h80000000, 32'h0F, 32'd0, 32'd14, 32'd2,
               32'hFFFFFFFF, 32'd5, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF, 32'd1};
        tt = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
               1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tl = '{1, 1, 1, 1, 1, 33, 33, 33, 1, 1, 1, 1, 1, 1, 33};
        for (int i = 0; i < 15; i++) begin
            run_op(tc[i], ta[i], tb[i], ts[i], lat);
            tests++;
            if (lat !== tl[i] || result !== tr[i] || zero !== (tr[i] == '0) ||
                branchTaken !== tt[i]) begin
                fails++;
                $display("FAIL plan[%0d] code %0d: lat=%0d res=%h z=%b bt=%b, required lat=%0d res=%h z=%b bt=%b",
                         i, tc[i], lat, result, zero, branchTaken, tl[i], tr[i],
                         (tr[i] == '0), tt[i]);
            end
        end
    endtask

    task automatic test_random_single;
        logic [3:0]   c;
        logic [W-1:0] a, b;
        logic [4:0]   sh;
        logic [W:0]   e;
        int           lat;
        for (int i = 0; i < 60; i++) begin
            c  = 4'($urandom_range(12, 0));
            a  = $urandom;
            b  = ($urandom_range(3, 0) == 0) ? a : $urandom;
            sh = 5'($urandom);
            e  = model(c, a, b, sh);
            run_op(c, a, b, sh, lat);
            tests++;
            if (lat !== 1 || result !== e[W-1:0] || zero !== (e[W-1:0] == '0) ||
                branchTaken !== e[W]) begin
                fails++;
                $display("FAIL single code %0d a=%h b=%h sh=%0d: lat=%0d res=%h z=%b bt=%b, required lat=1 res=%h bt=%b",
                         c, a, b, sh, lat, result, zero, branchTaken, e[W-1:0], e[W]);
            end
        end
    endtask

    task automatic test_random_iter;
        logic [3:0]   c;
        logic [W-1:0] a, b;
        logic [W:0]   e;
        int           lat, sel;
        for (int i = 0; i < 18; i++) begin
            c   = 4'(13 + $urandom_range(2, 0));
            sel = $urandom_range(4, 0);
            a   = ($urandom_range(1, 0) == 0) ? $urandom : 32'($urandom_range(500, 0));
            b   = (sel == 0) ? '0 : (sel == 1) ? 32'($urandom_range(20, 1)) : $urandom;
            e   = model(c, a, b, 5'd0);
            run_op(c, a, b, 5'd0, lat);
            tests++;
            if (lat !== exp_lat(c, b) || result !== e[W-1:0] ||
                zero !== (e[W-1:0] == '0) || branchTaken !== 1'b0) begin
                fails++;
                $display("FAIL iter code %0d a=%h b=%h: lat=%0d res=%h z=%b bt=%b, required lat=%0d res=%h bt=0",
                         c, a, b, lat, result, zero, branchTaken, exp_lat(c, b), e[W-1:0]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0]   c;
        logic [W-1:0] a, b;
        logic [4:0]   sh;
        logic [W:0]   e;
        aluCtrl = 4'd6;
        srcB    = 32'hF0;
        shamt   = 5'd4;
        start   = 1'b1;
        tick();
        tests++;
        if (done !== 1'b1 || result !== 32'h0F) begin
            fails++;
            $display("FAIL b2b_first: done=%b res=%h, required done=1 res=0000000f", done, result);
        end
        srcB = 32'hF000;
        tick();
        tests++;
        if (done !== 1'b1 || result !== 32'hF00) begin
            fails++;
            $display("FAIL b2b_second: done=%b res=%h, required done=1 res=00000f00", done, result);
        end
        for (int i = 0; i < 10; i++) begin
            c       = 4'($urandom_range(12, 0));
            a       = $urandom;
            b       = $urandom;
            sh      = 5'($urandom);
            e       = model(c, a, b, sh);
            aluCtrl = c;
            srcA    = a;
            srcB    = b;
            shamt   = sh;
            tick();
            tests++;
            if (done !== 1'b1 || busy !== 1'b0 || result !== e[W-1:0] ||
                branchTaken !== e[W]) begin
                fails++;
                $display("FAIL b2b_rand code %0d: done=%b busy=%b res=%h bt=%b, required done=1 busy=0 res=%h bt=%b",
                         c, done, busy, result, branchTaken, e[W-1:0], e[W]);
            end
        end
        start = 1'b0;
        tick();
        tests++;
        if (done !== 1'b0 || result !== e[W-1:0]) begin
            fails++;
            $display("FAIL b2b_tail: done=%b res=%h, required done=0 res=%h", done, result, e[W-1:0]);
        end
    endtask

    task automatic test_busy_ignore;
        int lat;
        run_op(4'd0, 32'd1, 32'd2, 5'd0, lat);
        aluCtrl = 4'd13;
        srcA    = 32'h10000;
        srcB    = 32'h10000;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        srcA    = $urandom;
        srcB    = $urandom;
        for (int k = 1; k <= W; k++) begin
            tests++;
            if (busy !== 1'b1 || done !== 1'b0 || result !== 32'd3) begin
                fails++;
                $display("FAIL mul_busy cycle t+%0d: busy=%b done=%b res=%h, required busy=1 done=0 res=00000003",
                         k, busy, done, result);
            end
            start = (k == 5);
            if (k == 5) begin
                aluCtrl = 4'd0;
                srcA    = 32'd1;
                srcB    = 32'd1;
            end
            tick();
        end
        start = 1'b0;
        tests++;
        if (done !== 1'b1 || busy !== 1'b0 || result !== 32'd0 || zero !== 1'b1) begin
            fails++;
            $display("FAIL mul_done: done=%b busy=%b res=%h z=%b, required done=1 busy=0 res=0 z=1",
                     done, busy, result, zero);
        end
        tick();
        tests++;
        if (done !== 1'b0 || result !== 32'd0) begin
            fails++;
            $display("FAIL mul_after: done=%b res=%h, required done=0 res=0", done, result);
        end
    endtask

    task automatic test_reset_abort;
        int lat, dones;
        run_op(4'd0, 32'd5, 32'd6, 5'd0, lat);
        aluCtrl = 4'd14;
        srcA    = 32'd1000;
        srcB    = 32'd3;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        for (int k = 0; k < 9; k++) tick();
        tests++;
        if (busy !== 1'b1 || result !== 32'd11) begin
            fails++;
            $display("FAIL abort_pre: busy=%b res=%h, required busy=1 res=0000000b", busy, result);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if ({result, zero, branchTaken, busy, done} !== '0) begin
            fails++;
            $display("FAIL abort_reset: res=%h z=%b bt=%b busy=%b done=%b, required all 0",
                     result, zero, branchTaken, busy, done);
        end
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1 || busy === 1'b1) dones++;
            tick();
        end
        tests++;
        if (dones !== 0) begin
            fails++;
            $display("FAIL abort_quiet: %0d cycles with done/busy, required 0", dones);
        end
        run_op(4'd0, 32'd20, 32'd22, 5'd0, lat);
        tests++;
        if (lat !== 1 || result !== 32'd42 || zero !== 1'b0) begin
            fails++;
            $display("FAIL abort_recover: lat=%0d res=%h z=%b, required lat=1 res=0000002a z=0",
                     lat, result, zero);
        end
    endtask

    initial begin
        test_reset();
        test_plan();
        test_random_single();
        test_random_iter();
        test_back_to_back();
        test_busy_ignore();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
